sdp_ram_be_sc: RTL and testbench
================================

Name: sdp_ram_be_sc

Overview:
Parametrised simple dual-port RAM (one write port, one read port, single clock). It is the next generation of the team's single-clock SDP RAM and adds:
- byte-lane write enables
- read enable with a valid strobe
- selectable read latency (1 or 2)
- a selectable read-during-write policy
- a hardware clear sequencer that replaces file-based reload on reset
Used as line/coefficient buffer storage in datapath blocks.

Parameters:
DATA_WIDTH, 32, word width; must be a multiple of BYTE_WIDTH
BYTE_WIDTH, 8, bits per write lane; NB = DATA_WIDTH/BYTE_WIDTH
ADDR_WIDTH, 8, address bits; DEPTH = 2**ADDR_WIDTH
RD_LATENCY, 1, read latency in cycles; legal values 1 or 2
RDW_MODE, 0, same-address read/write policy: 0 = old data, 1 = new data (lane-merged)
CLEAR_ON_RESET, 1, 1 = run clear sequence after reset, 0 = no clear
CLEAR_VALUE, 0, DATA_WIDTH value written to every word by the clear sequence

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
we  input  1  write request
be  input  NB  byte-lane enables; a lane is written only when we && be[i]
waddr  input  ADDR_WIDTH  write address
wdata  input  DATA_WIDTH  write data
re  input  1  read request
raddr  input  ADDR_WIDTH  read address
q  output  DATA_WIDTH  read data
q_valid  output  1  one-cycle pulse: q holds data for an accepted read
collision  output  1  pulse aligned with q_valid: that read hit a same-cycle write to the same address with any be set
busy  output  1  clear sequence in progress; requests are ignored
q_perr  output  NB  per-lane parity error, aligned with q_valid

Behaviour:
- Reset (rst=1 sampled at a clock edge):
  - q=0, q_valid=0, collision=0, q_perr=0, all pipeline stages flushed.
  - Clear FSM enters CLEAR with ptr=0 when CLEAR_ON_RESET=1; otherwise it enters IDLE.
  - busy=1 while rst=1 if CLEAR_ON_RESET=1, else busy=0.
- Clear FSM, states IDLE and CLEAR:
  - In CLEAR, each cycle with rst=0 writes CLEAR_VALUE to all lanes of ram[ptr], then ptr++.
  - After writing ptr=DEPTH-1, the FSM goes to IDLE and busy=0 on the next cycle.
  - busy is therefore high for exactly DEPTH cycles after rst is released.
  - Reset asserted mid-clear restarts the clear from ptr=0.
- While busy=1:
  - we and re are ignored; no memory writes from the port.
  - q_valid and collision stay 0; q holds its value.
- Write: for each lane i with we && be[i], ram[waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata lane i. Other lanes are unchanged.
- Read: re accepted at edge N gives q and q_valid=1 at edge N+RD_LATENCY.
  - With re=0, q holds its last value and q_valid=0.
  - Back-to-back reads are fully pipelined, one result per cycle.
- Collision (re && we && raddr==waddr && |be, same cycle):
  - RDW_MODE=0: q returns pre-write contents for all lanes.
  - RDW_MODE=1: lanes with be set return wdata; other lanes return old contents.
  - In both modes, collision=1 in the same cycle as that read's q_valid.
- A write to a different address in the same cycle has no effect on the read.
- RD_LATENCY=2: the second stage is a plain register on q, q_valid, collision and q_perr. No other timing changes.
- Any RD_LATENCY value other than 1 or 2, or DATA_WIDTH not a multiple of BYTE_WIDTH, is rejected with an elaboration-time error.

Optional Feature:
SDP_RAM_PARITY_EN:
- Defined:
  - Each lane stores one extra even-parity bit, computed from the written lane data.
  - The clear sequence writes the parity of the CLEAR_VALUE lanes.
  - On read, parity is recomputed per lane. q_perr[i]=1 on mismatch, aligned with q_valid.
  - In RDW_MODE=1, forwarded lanes use the forwarded data and parity.
- Undefined: no parity storage; q_perr is tied to 0.

Test Plan:
1. Clear sequence (DEPTH=256, CLEAR_VALUE=0xDEADBEEF): pulse rst for 1 cycle -> busy=1 for exactly 256 cycles; then read 0x00, 0x7F, 0xFF -> each returns 0xDEADBEEF with q_valid.
2. Byte enables: write 0xAABBCCDD be=4'b1111 at 0x10, then 0x11223344 be=4'b0101 at 0x10; read 0x10 -> q=0xAA22CC44.
3. Latency: RD_LATENCY=2, addresses 1,2,3 preloaded with 0x1,0x2,0x3; re at edges N..N+2 -> q_valid high at N+2..N+4 with q=0x1,0x2,0x3; q holds 0x3 afterwards with q_valid=0.
4. Collision: mem[0x20]=0x00000000; same cycle write 0xFFFFFFFF be=4'b0011 and read 0x20 -> RDW_MODE=0 gives q=0x00000000, collision=1; RDW_MODE=1 gives q=0x0000FFFF, collision=1; the next read of 0x20 gives 0x0000FFFF with collision=0.
5. Reset mid-clear: assert rst when ptr=100 -> busy stays 1; clear finishes exactly 256 cycles after release. re/we issued during busy produce no q_valid, and memory is unchanged afterwards.
6. SDP_RAM_PARITY_EN defined: write 0x000000FF at 0x05; force-flip the stored bit 0 via hierarchical deposit; read 0x05 -> q_perr=4'b0001. With the macro undefined -> q_perr=0.

Source files
------------

// File: rtl/sdp_ram_be_sc_if.sv
// ---------------------------------------------------------------------------
// sdp_ram_be_sc_if
// Bus bundle for the byte-enabled single-clock simple dual-port RAM.
//
// Signals:
//   we, be[NB], waddr, wdata    write request, lane enables, address, data
//   re, raddr                   read request and address
//   q, q_valid                  read data and its one-cycle valid strobe
//   collision                   read hit a same-cycle write to the same word
//   busy                        clear sequence running, requests ignored
//   q_perr[NB]                  per-lane parity error, aligned with q_valid
//
// Modports:
//   master  drives the requests (the client of the RAM)
//   slave   the RAM itself
// ---------------------------------------------------------------------------
interface sdp_ram_be_sc_if #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) ();
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;

    logic                  we;
    logic [NB-1:0]         be;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  re;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] q;
    logic                  q_valid;
    logic                  collision;
    logic                  busy;
    logic [NB-1:0]         q_perr;

    modport master (
        output we, be, waddr, wdata, re, raddr,
        input  q, q_valid, collision, busy, q_perr
    );

    modport slave (
        input  we, be, waddr, wdata, re, raddr,
        output q, q_valid, collision, busy, q_perr
    );
endinterface

// File: rtl/sdp_ram_be_sc.sv
// ---------------------------------------------------------------------------
// sdp_ram_be_sc
// Single-clock simple dual-port RAM with byte-lane write enables, read enable
// with valid strobe, read latency 1 or 2, selectable read-during-write policy
// and a hardware clear sequencer that runs after reset.
//
// Ports:
//   clk   clock, everything on the rising edge
//   rst   synchronous active-high reset
//   bus   sdp_ram_be_sc_if.slave: write port (we/be/waddr/wdata), read port
//         (re/raddr -> q/q_valid/collision/q_perr), busy status
//
// Optional feature macro: SDP_RAM_PARITY_EN
//   defined   -> one even-parity bit stored per lane, checked on read (q_perr)
//   undefined -> no parity storage, q_perr is constant 0
// ---------------------------------------------------------------------------
module sdp_ram_be_sc #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    BYTE_WIDTH     = 8,
    parameter int                    ADDR_WIDTH     = 8,
    parameter int                    RD_LATENCY     = 1,
    parameter int                    RDW_MODE       = 0,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic            clk,
    input  logic            rst,
    sdp_ram_be_sc_if.slave  bus
);
    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    generate
        if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
            $error("sdp_ram_be_sc: RD_LATENCY must be 1 or 2");
        end
        if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
            $error("sdp_ram_be_sc: DATA_WIDTH must be a multiple of BYTE_WIDTH");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t                state_reg;
    logic [ADDR_WIDTH-1:0] ptr_reg;
    logic                  busy_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
            if (CLEAR_ON_RESET != 0) begin
                state_reg <= ST_CLEAR;
                busy_reg  <= 1'b1;
            end else begin
                state_reg <= ST_IDLE;
                busy_reg  <= 1'b0;
            end
        end else begin
            case (state_reg)
                ST_CLEAR: begin
                    ptr_reg <= ptr_reg + 1'b1;
                    // Last word written this cycle: release the port next cycle.
                    if (&ptr_reg) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write-side muxing: the clear sequencer owns the write port while busy
    // ------------------------------------------------------------------
    logic                  clearing;
    logic                  accept;
    logic                  rd_fire;
    logic                  coll;
    logic [NB-1:0]         wr_lane;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NB-1:0]         fwd_lane;

    assign clearing = (state_reg == ST_CLEAR) && !rst;
    assign accept   = !rst && !busy_reg;
    assign rd_fire  = accept && bus.re;
    assign coll     = rd_fire && bus.we && (bus.raddr == bus.waddr) && (|bus.be);
    assign wr_lane  = clearing ? {NB{1'b1}} : ((accept && bus.we) ? bus.be : '0);
    assign wr_addr  = clearing ? ptr_reg : bus.waddr;
    assign wr_data  = clearing ? CLEAR_VALUE : bus.wdata;
    // Lanes whose read result is taken from the concurrent write (new-data mode).
    assign fwd_lane = (RDW_MODE == 1 && coll) ? bus.be : '0;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_word;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_lane[i]) begin
                mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    assign rd_word = mem[bus.raddr];

`ifdef SDP_RAM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic [NB-1:0] rd_par;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_lane[i]) begin
                par_mem[wr_addr][i] <= ^wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    assign rd_par = par_mem[bus.raddr];
`endif

    // ------------------------------------------------------------------
    // Per-lane read merge and parity check
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rd_merged;
    logic [NB-1:0]         perr_next;

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            logic [BYTE_WIDTH-1:0] lane_data;

            assign lane_data = fwd_lane[gi] ? bus.wdata[gi*BYTE_WIDTH +: BYTE_WIDTH]
                                            : rd_word[gi*BYTE_WIDTH +: BYTE_WIDTH];
            assign rd_merged[gi*BYTE_WIDTH +: BYTE_WIDTH] = lane_data;
`ifdef SDP_RAM_PARITY_EN
            logic lane_par;
            // A forwarded lane carries the parity of the data being written.
            assign lane_par      = fwd_lane[gi] ? ^bus.wdata[gi*BYTE_WIDTH +: BYTE_WIDTH]
                                                : rd_par[gi];
            assign perr_next[gi] = (^lane_data) ^ lane_par;
`else
            assign perr_next[gi] = 1'b0;
`endif
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read stage 1 (registered read)
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] q1_reg;
    logic                  valid1_reg;
    logic                  coll1_reg;
    logic [NB-1:0]         perr1_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            q1_reg     <= '0;
            valid1_reg <= 1'b0;
            coll1_reg  <= 1'b0;
            perr1_reg  <= '0;
        end else begin
            valid1_reg <= rd_fire;
            coll1_reg  <= coll;
            perr1_reg  <= rd_fire ? perr_next : '0;
            if (rd_fire) begin
                q1_reg <= rd_merged;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional second output stage
    // ------------------------------------------------------------------
    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] q2_reg;
            logic                  valid2_reg;
            logic                  coll2_reg;
            logic [NB-1:0]         perr2_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    q2_reg     <= '0;
                    valid2_reg <= 1'b0;
                    coll2_reg  <= 1'b0;
                    perr2_reg  <= '0;
                end else begin
                    valid2_reg <= valid1_reg;
                    coll2_reg  <= coll1_reg;
                    perr2_reg  <= perr1_reg;
                    q2_reg     <= q1_reg;
                end
            end

            assign bus.q         = q2_reg;
            assign bus.q_valid   = valid2_reg;
            assign bus.collision = coll2_reg;
            assign bus.q_perr    = perr2_reg;
        end else begin : g_lat1
            assign bus.q         = q1_reg;
            assign bus.q_valid   = valid1_reg;
            assign bus.collision = coll1_reg;
            assign bus.q_perr    = perr1_reg;
        end
    endgenerate

    assign bus.busy = busy_reg;

endmodule

// File: tb/tb_sdp_ram_be_sc.sv
// ---------------------------------------------------------------------------
// tb_sdp_ram_be_sc
// Directed bench for sdp_ram_be_sc. Two instances share one stimulus:
//   dut_a: RD_LATENCY=1, RDW_MODE=0 (old data on collision)
//   dut_b: RD_LATENCY=2, RDW_MODE=1 (new data, lane-merged)
// Both clear to 0xDEADBEEF after reset. Outputs are sampled 1 time unit after
// each rising edge, so a value seen after edge K is what a consumer samples
// at edge K+1.
// ---------------------------------------------------------------------------
module tb_sdp_ram_be_sc;
    localparam int DW = 32;
    localparam int BW = 8;
    localparam int AW = 8;
    localparam logic [31:0] CV = 32'hDEADBEEF;

    logic clk;
    logic rst;

    logic          we;
    logic [3:0]    be;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          re;
    logic [AW-1:0] raddr;

    int checks   = 0;
    int failures = 0;

    sdp_ram_be_sc_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW)) if_a ();
    sdp_ram_be_sc_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW)) if_b ();

    assign if_a.we = we;  assign if_a.be = be;  assign if_a.waddr = waddr;
    assign if_a.wdata = wdata;  assign if_a.re = re;  assign if_a.raddr = raddr;
    assign if_b.we = we;  assign if_b.be = be;  assign if_b.waddr = waddr;
    assign if_b.wdata = wdata;  assign if_b.re = re;  assign if_b.raddr = raddr;

    sdp_ram_be_sc #(
        .DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW),
        .RD_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a.slave)
    );

    sdp_ram_be_sc #(
        .DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW),
        .RD_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] m);
        we = 1'b1; waddr = a; wdata = d; be = m;
        tick();
        we = 1'b0; be = 4'h0;
    endtask

    // Single read; any write set up by the caller happens in the same cycle.
    task automatic rd(input logic [AW-1:0] a, input logic [31:0] exp_a, input logic [31:0] exp_b,
                      input logic coll_a, input logic coll_b, input logic [3:0] perr, input string tag);
        re = 1'b1; raddr = a;
        tick();
        re = 1'b0; we = 1'b0; be = 4'h0;
        chk({tag, "_a_valid"}, 32'(if_a.q_valid), 32'd1);
        chk({tag, "_a_q"}, if_a.q, exp_a);
        chk({tag, "_a_coll"}, 32'(if_a.collision), 32'(coll_a));
        chk({tag, "_a_perr"}, 32'(if_a.q_perr), 32'(perr));
        chk({tag, "_b_early"}, 32'(if_b.q_valid), 32'd0);
        tick();
        chk({tag, "_a_done"}, 32'(if_a.q_valid), 32'd0);
        chk({tag, "_b_valid"}, 32'(if_b.q_valid), 32'd1);
        chk({tag, "_b_q"}, if_b.q, exp_b);
        chk({tag, "_b_coll"}, 32'(if_b.collision), 32'(coll_b));
        chk({tag, "_b_perr"}, 32'(if_b.q_perr), 32'(perr));
    endtask

    initial begin
        int n;
        int vcount;

        rst = 1'b1; we = 1'b0; be = 4'h0; waddr = '0; wdata = '0; re = 1'b0; raddr = '0;
        tick();
        tick();

        // Reset state
        chk("rst_a_q", if_a.q, 32'h0);
        chk("rst_a_valid", 32'(if_a.q_valid), 32'd0);
        chk("rst_a_coll", 32'(if_a.collision), 32'd0);
        chk("rst_a_busy", 32'(if_a.busy), 32'd1);
        chk("rst_a_perr", 32'(if_a.q_perr), 32'd0);
        chk("rst_b_q", if_b.q, 32'h0);
        chk("rst_b_valid", 32'(if_b.q_valid), 32'd0);
        chk("rst_b_busy", 32'(if_b.busy), 32'd1);

        // Clear sequence: busy for exactly 256 cycles after release
        rst = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (if_a.busy && n < 400);
        chk("clear_len", 32'(n), 32'd256);
        chk("clear_b_busy", 32'(if_b.busy), 32'd0);
        rd(8'h00, CV, CV, 1'b0, 1'b0, 4'h0, "clr00");
        rd(8'h7F, CV, CV, 1'b0, 1'b0, 4'h0, "clr7f");
        rd(8'hFF, CV, CV, 1'b0, 1'b0, 4'h0, "clrff");

        // Byte enables
        wr(8'h10, 32'hAABBCCDD, 4'b1111);
        wr(8'h10, 32'h11223344, 4'b0101);
        rd(8'h10, 32'hAA22CC44, 32'hAA22CC44, 1'b0, 1'b0, 4'h0, "be");

        // Pipelined reads of 1,2,3
        wr(8'h01, 32'h1, 4'hF);
        wr(8'h02, 32'h2, 4'hF);
        wr(8'h03, 32'h3, 4'hF);
        re = 1'b1; raddr = 8'h01;
        tick();
        chk("pipe0_a_q", if_a.q, 32'h1);
        chk("pipe0_a_valid", 32'(if_a.q_valid), 32'd1);
        chk("pipe0_b_valid", 32'(if_b.q_valid), 32'd0);
        raddr = 8'h02;
        tick();
        chk("pipe1_a_q", if_a.q, 32'h2);
        chk("pipe1_b_q", if_b.q, 32'h1);
        chk("pipe1_b_valid", 32'(if_b.q_valid), 32'd1);
        raddr = 8'h03;
        tick();
        chk("pipe2_a_q", if_a.q, 32'h3);
        chk("pipe2_b_q", if_b.q, 32'h2);
        chk("pipe2_b_valid", 32'(if_b.q_valid), 32'd1);
        re = 1'b0;
        tick();
        chk("pipe3_a_valid", 32'(if_a.q_valid), 32'd0);
        chk("pipe3_a_hold", if_a.q, 32'h3);
        chk("pipe3_b_q", if_b.q, 32'h3);
        chk("pipe3_b_valid", 32'(if_b.q_valid), 32'd1);
        tick();
        chk("pipe4_b_valid", 32'(if_b.q_valid), 32'd0);
        chk("pipe4_b_hold", if_b.q, 32'h3);

        // Collision: same-address write with be=0011
        wr(8'h20, 32'h0, 4'hF);
        we = 1'b1; waddr = 8'h20; wdata = 32'hFFFFFFFF; be = 4'b0011;
        rd(8'h20, 32'h00000000, 32'h0000FFFF, 1'b1, 1'b1, 4'h0, "coll");
        rd(8'h20, 32'h0000FFFF, 32'h0000FFFF, 1'b0, 1'b0, 4'h0, "after_coll");
        // Different-address write in the same cycle does not disturb the read
        we = 1'b1; waddr = 8'h21; wdata = 32'h12345678; be = 4'hF;
        rd(8'h20, 32'h0000FFFF, 32'h0000FFFF, 1'b0, 1'b0, 4'h0, "diff_addr");
        // Same address but no lanes enabled: no collision, no change
        we = 1'b1; waddr = 8'h20; wdata = 32'hA5A5A5A5; be = 4'h0;
        rd(8'h20, 32'h0000FFFF, 32'h0000FFFF, 1'b0, 1'b0, 4'h0, "be_zero");
        rd(8'h21, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 4'h0, "rd21");

        // Reset mid-clear restarts the clear; port requests ignored while busy
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (100) tick();
        chk("mid_busy", 32'(if_a.busy), 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", 32'(if_a.busy), 32'd1);
        rst = 1'b0;
        we = 1'b1; waddr = 8'h10; wdata = 32'h55555555; be = 4'hF;
        re = 1'b1; raddr = 8'h10;
        n = 0;
        vcount = 0;
        do begin
            tick();
            n++;
            if (if_a.q_valid || if_b.q_valid) vcount++;
        end while (if_a.busy && n < 400);
        we = 1'b0; re = 1'b0; be = 4'h0;
        chk("reclear_len", 32'(n), 32'd256);
        chk("busy_no_valid", 32'(vcount), 32'd0);
        chk("busy_hold_q", if_a.q, 32'h0);
        rd(8'h10, CV, CV, 1'b0, 1'b0, 4'h0, "busy_nowrite");
        rd(8'h20, CV, CV, 1'b0, 1'b0, 4'h0, "reclear20");

        // Parity
        wr(8'h05, 32'h000000FF, 4'hF);
`ifdef SDP_RAM_PARITY_EN
        dut_a.mem[5][0] = ~dut_a.mem[5][0];
        dut_b.mem[5][0] = ~dut_b.mem[5][0];
        rd(8'h05, 32'h000000FE, 32'h000000FE, 1'b0, 1'b0, 4'b0001, "perr");
`else
        rd(8'h05, 32'h000000FF, 32'h000000FF, 1'b0, 1'b0, 4'b0000, "perr");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
